// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared MMU memory port (core C, debug/DMA D).
// Zero-latency grant, bounded port locking, and owner-tagged read/exception return.
package mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;

  typedef logic [3:0] mem_exception_mask_t;
endpackage

// state    | meaning
// S_OPEN   | no lock, arbitrate between requesters
// S_LOCK_C | C holds the port
// S_LOCK_D | D holds the port
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int CORE_PRIORITY = 0,
  parameter int LOCK_MAX      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                d_req,
  input  logic [31:0]         c_addr,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         c_wr_data,
  input  logic [31:0]         d_wr_data,
  input  logic                c_wr_ena,
  input  logic                d_wr_ena,
  input  mem_access_t         c_access,
  input  mem_access_t         d_access,
  input  logic                c_lock,
  input  logic                d_lock,
  output logic                c_gnt,
  output logic                d_gnt,
  output logic                c_rd_valid,
  output logic                d_rd_valid,
  output logic [31:0]         c_rd_data,
  output logic [31:0]         d_rd_data,
  output mem_exception_mask_t c_exception,
  output mem_exception_mask_t d_exception,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [31:0]         mem_rd_data,
  input  mem_exception_mask_t mem_exception
);

  localparam logic [1:0] S_OPEN   = 2'd0;
  localparam logic [1:0] S_LOCK_C = 2'd1;
  localparam logic [1:0] S_LOCK_D = 2'd2;

  logic [1:0] state, state_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       last_gnt, last_gnt_nxt;   // 1 = D granted most recently
  logic       d_bonus, d_bonus_nxt;     // D owed one contention after C was forced off
  logic       resp_valid, resp_owner;
  logic       c_win, c_gnt_raw, d_gnt_raw;
  logic       any_gnt, own_lock, lock_room;
  logic [8:0] lock_cnt_inc;

  assign c_win = (CORE_PRIORITY != 0) ? !d_bonus : last_gnt;

  always_comb begin
    c_gnt_raw = 1'b0;
    d_gnt_raw = 1'b0;
    case (state)
      S_LOCK_C: c_gnt_raw = c_req;
      S_LOCK_D: d_gnt_raw = d_req;
      default: begin
        if (c_req && d_req) begin
          c_gnt_raw = c_win;
          d_gnt_raw = !c_win;
        end else begin
          c_gnt_raw = c_req;
          d_gnt_raw = d_req;
        end
      end
    endcase
  end

  assign c_gnt   = rst && c_gnt_raw;
  assign d_gnt   = rst && d_gnt_raw;
  assign any_gnt = c_gnt || d_gnt;

  assign own_lock     = c_gnt ? c_lock : d_lock;
  assign lock_cnt_inc = {1'b0, lock_cnt} + 9'd1;
  assign lock_room    = lock_cnt_inc < 9'(LOCK_MAX);

  // Any cycle without a grant (including a locked owner dropping req) reopens the port.
  always_comb begin
    state_nxt    = S_OPEN;
    lock_cnt_nxt = '0;
    last_gnt_nxt = last_gnt;
    d_bonus_nxt  = d_bonus;
    if (any_gnt) begin
      last_gnt_nxt = d_gnt;
      if (own_lock && lock_room) begin
        state_nxt    = d_gnt ? S_LOCK_D : S_LOCK_C;
        lock_cnt_nxt = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
      end else if (own_lock && c_gnt && (CORE_PRIORITY != 0)) begin
        d_bonus_nxt = 1'b1;
      end
      if (d_gnt && (state == S_OPEN) && c_req) begin
        d_bonus_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_OPEN;
      lock_cnt   <= '0;
      last_gnt   <= 1'b1;
      d_bonus    <= 1'b0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      state      <= state_nxt;
      lock_cnt   <= lock_cnt_nxt;
      last_gnt   <= last_gnt_nxt;
      d_bonus    <= d_bonus_nxt;
      resp_valid <= any_gnt && !mem_wr_ena;
      resp_owner <= d_gnt;
    end
  end

  assign mem_addr    = c_gnt ? c_addr    : (d_gnt ? d_addr    : 32'd0);
  assign mem_wr_data = c_gnt ? c_wr_data : (d_gnt ? d_wr_data : 32'd0);
  assign mem_wr_ena  = c_gnt ? c_wr_ena  : (d_gnt && d_wr_ena);
  assign mem_access  = c_gnt ? c_access  : (d_gnt ? d_access  : MEM_BYTE);

  assign c_rd_valid = rst && resp_valid && !resp_owner;
  assign d_rd_valid = rst && resp_valid && resp_owner;
  assign c_rd_data  = c_rd_valid ? mem_rd_data : 32'd0;
  assign d_rd_data  = d_rd_valid ? mem_rd_data : 32'd0;

  assign c_exception = c_gnt ? mem_exception : '0;
  assign d_exception = d_gnt ? mem_exception : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances (round-robin, core priority,
// LOCK_MAX=4) share stimulus; only the instance under test has its monitor enabled.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] CA  = 32'h0000_0010;
  localparam logic [31:0] DA  = 32'h8000_0040;
  localparam logic [31:0] CWD = 32'h1111_2222;
  localparam logic [31:0] DWD = 32'h3333_4444;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  typedef struct packed {
    logic [31:0] cyc;
    logic        cg, dg, cv, dv, we;
    logic [1:0]  acc;
    logic [31:0] addr, wd, crd, drd;
    logic [3:0]  cx, dx;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_req, d_req, c_wr_ena, d_wr_ena, c_lock, d_lock;
  logic [31:0] c_addr, d_addr, c_wr_data, d_wr_data;
  mem_access_t c_access, d_access;
  mem_exception_mask_t exc_drive;

  logic                c_gnt_o[3], d_gnt_o[3], c_rv_o[3], d_rv_o[3], mem_we_o[3];
  logic [31:0]         c_rdd_o[3], d_rdd_o[3], mem_addr_o[3], mem_wd_o[3], rdd[3];
  mem_access_t         mem_acc_o[3];
  mem_exception_mask_t c_exc_o[3], d_exc_o[3];

  logic [31:0] cyc = 32'd0;
  logic [2:0]  mon_en, zchk, idle_chk;
  logic        drain;
  logic        pend_c, pend_d;
  ev_t         exp_q[3][$];
  int          n_vec = 0;
  int          n_miss = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .CORE_PRIORITY(g == 1 ? 1 : 0),
      .LOCK_MAX     (g == 2 ? 4 : 8)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .c_req        (c_req),
      .d_req        (d_req),
      .c_addr       (c_addr),
      .d_addr       (d_addr),
      .c_wr_data    (c_wr_data),
      .d_wr_data    (d_wr_data),
      .c_wr_ena     (c_wr_ena),
      .d_wr_ena     (d_wr_ena),
      .c_access     (c_access),
      .d_access     (d_access),
      .c_lock       (c_lock),
      .d_lock       (d_lock),
      .c_gnt        (c_gnt_o[g]),
      .d_gnt        (d_gnt_o[g]),
      .c_rd_valid   (c_rv_o[g]),
      .d_rd_valid   (d_rv_o[g]),
      .c_rd_data    (c_rdd_o[g]),
      .d_rd_data    (d_rdd_o[g]),
      .c_exception  (c_exc_o[g]),
      .d_exception  (d_exc_o[g]),
      .mem_addr     (mem_addr_o[g]),
      .mem_wr_data  (mem_wd_o[g]),
      .mem_wr_ena   (mem_we_o[g]),
      .mem_access   (mem_acc_o[g]),
      .mem_rd_data  (rdd[g]),
      .mem_exception(exc_drive)
    );
  end

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    for (int i = 0; i < 3; i++) rdd[i] <= mem_addr_o[i] ^ KEY;
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d gnt=%b%b rv=%b%b we=%b acc=%0d addr=%h wd=%h rd=%h/%h exc=%h/%h",
                     e.cyc, e.cg, e.dg, e.cv, e.dv, e.we, e.acc, e.addr, e.wd, e.crd, e.drd,
                     e.cx, e.dx);
  endfunction

  // Monitor: pops one expectation per active cycle; also services zero/idle/drain checks.
  always @(negedge clk) begin : monitor
    ev_t got, e;
    for (int i = 0; i < 3; i++) begin
      got      = '0;
      got.cyc  = cyc;
      got.cg   = c_gnt_o[i];
      got.dg   = d_gnt_o[i];
      got.cv   = c_rv_o[i];
      got.dv   = d_rv_o[i];
      got.we   = mem_we_o[i];
      got.acc  = mem_acc_o[i];
      got.addr = mem_addr_o[i];
      got.wd   = mem_wd_o[i];
      got.crd  = c_rdd_o[i];
      got.drd  = d_rdd_o[i];
      got.cx   = c_exc_o[i];
      got.dx   = d_exc_o[i];
      if (mon_en[i] && (got.cg || got.dg || got.cv || got.dv)) begin
        n_vec = n_vec + 1;
        if (exp_q[i].size() == 0) begin
          n_miss = n_miss + 1;
          $display("FAIL sb%0d unexpected: got %s, required nothing", i, fmt(got));
        end else begin
          e = exp_q[i].pop_front();
          if (got !== e) begin
            n_miss = n_miss + 1;
            $display("FAIL sb%0d event: got %s, required %s", i, fmt(got), fmt(e));
          end
        end
      end
      if (mon_en[i] && zchk[i]) begin
        n_vec = n_vec + 1;
        e = '0;
        e.cyc = cyc;
        if (got !== e) begin
          n_miss = n_miss + 1;
          $display("FAIL reset%0d outputs: got %s, required all zero", i, fmt(got));
        end
      end
      if (mon_en[i] && idle_chk[i]) begin
        n_vec = n_vec + 1;
        if (got.cg || got.dg || got.we || got.acc != 2'd0 || got.addr != 32'd0 || got.wd != 32'd0) begin
          n_miss = n_miss + 1;
          $display("FAIL idle%0d port: got %s, required no grant and zero port", i, fmt(got));
        end
      end
      if (drain) begin
        n_vec = n_vec + 1;
        if (exp_q[i].size() != 0) begin
          n_miss = n_miss + 1;
          $display("FAIL drain%0d: got %0d unmatched expectations, required 0", i, exp_q[i].size());
        end
      end
    end
  end

  // One cycle of stimulus with hand-computed grant outcome (eg_c/eg_d).
  task automatic step(input int idx, input logic cr, cl, cw, dr, dl, dw,
                      input logic eg_c, eg_d, input logic rst_edge);
    ev_t e;
    c_req = cr; c_lock = cl; c_wr_ena = cw;
    d_req = dr; d_lock = dl; d_wr_ena = dw;
    e      = '0;
    e.cyc  = cyc;
    e.cg   = eg_c;
    e.dg   = eg_d;
    e.we   = eg_c ? cw : (eg_d ? dw : 1'b0);
    e.acc  = eg_c ? 2'(MEM_WORD) : (eg_d ? 2'(MEM_HALF) : 2'(MEM_BYTE));
    e.addr = eg_c ? CA : (eg_d ? DA : 32'd0);
    e.wd   = eg_c ? CWD : (eg_d ? DWD : 32'd0);
    e.cv   = pend_c;
    e.dv   = pend_d;
    e.crd  = pend_c ? (CA ^ KEY) : 32'd0;
    e.drd  = pend_d ? (DA ^ KEY) : 32'd0;
    e.cx   = eg_c ? exc_drive : 4'h0;
    e.dx   = eg_d ? exc_drive : 4'h0;
    if (e.cg || e.dg || e.cv || e.dv) exp_q[idx].push_back(e);
    idle_chk[idx] = !(eg_c || eg_d);
    pend_c = eg_c && !cw;
    pend_d = eg_d && !dw;
    @(negedge clk);
    #1;
    idle_chk[idx] = 1'b0;
    if (rst_edge) begin
      rst = 1'b0;
      pend_c = 1'b0;
      pend_d = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int idx, input int n);
    rst = 1'b0;
    pend_c = 1'b0;
    pend_d = 1'b0;
    zchk[idx] = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    zchk[idx] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle(input int idx);
    step(idx, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    c_req = 0; d_req = 0; c_wr_ena = 0; d_wr_ena = 0; c_lock = 0; d_lock = 0;
    c_addr = CA; d_addr = DA; c_wr_data = CWD; d_wr_data = DWD;
    c_access = MEM_WORD; d_access = MEM_HALF;
    exc_drive = '0;
    mon_en = 3'b001; zchk = '0; idle_chk = '0; drain = 1'b0;
    pend_c = 1'b0; pend_d = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin instance: single requester, store, exceptions
    hold_reset(0, 2);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);
    step(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    idle(0);
    exc_drive = 4'h5;
    step(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    exc_drive = 4'hA;
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    exc_drive = 4'h0;
    idle(0);

    // Continuous contention from reset alternates C,D,C,D
    hold_reset(0, 1);
    step(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    idle(0);

    // D locks for three grants, then releases; then D drops req while locked
    hold_reset(0, 1);
    step(0, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0);

    // Reset lands right after a D load: no response, then C wins first contention
    step(0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    c_req = 1'b1;
    d_req = 1'b1;
    hold_reset(0, 2);
    step(0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(0);

    // Core-priority instance
    mon_en = 3'b010;
    hold_reset(1, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    idle(1);
    hold_reset(1, 1);
    for (int k = 0; k < 8; k++) step(1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    idle(1);

    // LOCK_MAX=4 instance: C locks permanently, D waiting
    mon_en = 3'b100;
    hold_reset(2, 1);
    for (int k = 0; k < 4; k++) step(2, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    step(2, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    step(2, 1, 1, 0, 1, 0, 0, 1, 0, 0);
    idle(2);

    drain = 1'b1;
    @(negedge clk);
    #1;
    drain = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
